// File: rtl/char_stream_arbiter.sv
// ---------------------------------------------------------------------------
// char_stream_arbiter
//
// Merges two character streams into a single write port of a character
// feeder. Source A is the local keyboard and source B is the remote UART.
// Each source has its own small FIFO. An issue FSM drains the FIFOs one
// character at a time, and after each write strobe it waits a fixed gap
// before it can issue again. It also tracks a page character counter.
//
// Parameters
//   FIFO_DEPTH : entries per source FIFO (power of 2, >= 2)
//   GAP_CYCLES : idle cycles after every feed_we pulse (>= 1)
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   a_data/a_valid      : source A character and valid
//   a_ready             : source A FIFO can accept
//   b_data/b_valid      : source B character and valid
//   b_ready             : source B FIFO can accept
//   hold                : blocks new issues while high (an active gap still runs)
//   feed_data           : character code presented to the feeder
//   feed_we             : one-cycle write strobe to the feeder
//   feed_src            : origin of feed_data (0 = A, 1 = B)
//   char_count          : characters issued since the last clear (0..139)
//   page_full           : pulses together with feed_we on the 140th character
// ---------------------------------------------------------------------------
module char_stream_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic       hold,
  output logic [7:0] feed_data,
  output logic       feed_we,
  output logic       feed_src,
  output logic [7:0] char_count,
  output logic       page_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [7:0]    CLEAR_CODE = 8'hFF;
  localparam logic [7:0]    PAGE_LAST  = 8'd139;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  // Per-source FIFO storage. Index 0 is source A and index 1 is source B.
  // The pointers carry one extra wrap bit, so full and empty can be told apart.
  logic [7:0]  mem_q    [2][FIFO_DEPTH];
  logic [AW:0] wr_ptr_q [2];
  logic [AW:0] rd_ptr_q [2];
  logic [AW:0] wr_ptr_d [2];
  logic [AW:0] rd_ptr_d [2];

  logic [7:0]  in_data  [2];
  logic [7:0]  head     [2];
  logic [1:0]  in_valid;
  logic [1:0]  push;
  logic [1:0]  pop;
  logic [1:0]  empty;
  logic [1:0]  full;

  // Issue FSM state and registered outputs
  state_t      state_q;
  logic [GW-1:0] gap_cnt_q;
  logic        feed_we_q;
  logic [7:0]  feed_data_q;
  logic        feed_src_q;
  logic [7:0]  char_count_q;
  logic        page_full_q;
  logic        rr_last_q;     // source that won the most recent grant

  logic        issue;
  logic        grant_src;
  logic [7:0]  issue_data;
  logic        clear_a;
  logic        clear_b;

  // A clear code resets the page. Any other code advances the counter,
  // which wraps to 0 after the last position of the page.
  function automatic logic [7:0] next_count(input logic [7:0] cnt,
                                            input logic [7:0] code);
    logic [7:0] r;
    if (code == CLEAR_CODE) begin
      r = 8'd0;
    end else if (cnt == PAGE_LAST) begin
      r = 8'd0;
    end else begin
      r = cnt + 8'd1;
    end
    return r;
  endfunction

  function automatic logic wraps_page(input logic [7:0] cnt,
                                      input logic [7:0] code);
    return (code != CLEAR_CODE) && (cnt == PAGE_LAST);
  endfunction

  // ---------------------------------------------------------------------
  // FIFO status and accept logic
  // ---------------------------------------------------------------------
  always_comb begin
    in_valid   = {b_valid, a_valid};
    in_data[0] = a_data;
    in_data[1] = b_data;
    for (int s = 0; s < 2; s++) begin
      empty[s] = (wr_ptr_q[s] == rd_ptr_q[s]);
      full[s]  = (wr_ptr_q[s][AW] != rd_ptr_q[s][AW]) &&
                 (wr_ptr_q[s][AW-1:0] == rd_ptr_q[s][AW-1:0]);
      head[s]  = mem_q[s][rd_ptr_q[s][AW-1:0]];
      // Full blocks a push, so a push and a pop can never hit the same
      // entry. A pop on a full FIFO frees ready on the following cycle.
      push[s]  = in_valid[s] & ~full[s] & ~rst;
    end
  end

  assign a_ready = ~rst & ~full[0];
  assign b_ready = ~rst & ~full[1];

  // ---------------------------------------------------------------------
  // Grant selection: a clear code at a head wins, and A wins if both heads
  // hold a clear. Otherwise the grant alternates when both FIFOs have data.
  // ---------------------------------------------------------------------
  always_comb begin
    clear_a   = ~empty[0] && (head[0] == CLEAR_CODE);
    clear_b   = ~empty[1] && (head[1] == CLEAR_CODE);
    grant_src = 1'b0;
    if (clear_a) begin
      grant_src = 1'b0;
    end else if (clear_b) begin
      grant_src = 1'b1;
    end else if (~empty[0] && ~empty[1]) begin
      grant_src = ~rr_last_q;
    end else if (~empty[0]) begin
      grant_src = 1'b0;
    end else begin
      grant_src = 1'b1;
    end
    issue      = (state_q == IDLE) && ~hold && (~empty[0] || ~empty[1]);
    issue_data = head[grant_src];
    pop[0]     = issue & ~grant_src;
    pop[1]     = issue &  grant_src;
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s];
      rd_ptr_d[s] = rd_ptr_q[s];
      if (push[s]) begin
        wr_ptr_d[s] = wr_ptr_q[s] + (AW+1)'(1);
      end
      if (pop[s]) begin
        rd_ptr_d[s] = rd_ptr_q[s] + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
      end else begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
      end
    end
  end

  // Storage needs no reset, because the pointers decide what is valid.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        mem_q[s][wr_ptr_q[s][AW-1:0]] <= in_data[s];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Issue FSM: IDLE issues one character and enters GAP. GAP counts
  // GAP_CYCLES cycles and then returns to IDLE. hold is not sampled in GAP.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      feed_we_q    <= 1'b0;
      feed_data_q  <= 8'd0;
      feed_src_q   <= 1'b0;
      char_count_q <= 8'd0;
      page_full_q  <= 1'b0;
      rr_last_q    <= 1'b1;   // B won "last", so A takes the first tie
    end else begin
      feed_we_q   <= 1'b0;
      page_full_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue) begin
            feed_we_q    <= 1'b1;
            feed_data_q  <= issue_data;
            feed_src_q   <= grant_src;
            rr_last_q    <= grant_src;
            char_count_q <= next_count(char_count_q, issue_data);
            page_full_q  <= wraps_page(char_count_q, issue_data);
            gap_cnt_q    <= '0;
            state_q      <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign feed_we    = feed_we_q;
  assign feed_data  = feed_data_q;
  assign feed_src   = feed_src_q;
  assign char_count = char_count_q;
  assign page_full  = page_full_q;

endmodule

// File: doc/char_stream_arbiter.md
CHAR_STREAM_ARBITER -- requirements
Module: char_stream_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, per-source buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, idle cycles enforced after each feed_we pulse (>=1).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports a_data, input, 8, and a_valid, input, 1: source A (local keyboard) character and valid.
REQ-006 SHALL have port a_ready, output, 1: source A FIFO can accept.
REQ-007 SHALL have ports b_data, input, 8, b_valid, input, 1, and b_ready, output, 1: same as A for source B (remote UART).
REQ-008 SHALL have port hold, input, 1: when high, no new character is issued.
REQ-009 SHALL have port feed_data, output, 8: raw code driven to the character feeder idi input.
REQ-010 SHALL have port feed_we, output, 1: one-cycle write strobe to the character feeder.
REQ-011 SHALL have port feed_src, output, 1: source of the current feed_data (0=A, 1=B).
REQ-012 SHALL have port char_count, output, 8: characters issued since last clear, range 0..139.
REQ-013 SHALL have port page_full, output, 1: one-cycle pulse when the 140th character is issued.

Function
REQ-014 SHALL accept a character from a source on a clock edge where valid and ready are both high; x_ready = not(FIFO full).
REQ-015 SHALL store accepted characters in per-source FIFOs, preserving order; no character is ever dropped or duplicated.
REQ-016 SHALL implement FSM states IDLE and GAP.
REQ-017 In IDLE, with hold low and at least one FIFO non-empty, SHALL at the next edge pop one head, load feed_data/feed_src, drive feed_we=1, and enter GAP.
REQ-018 In GAP, SHALL hold feed_we=0 and count GAP_CYCLES cycles, then return to IDLE; hold does not abort GAP.
REQ-019 Minimum spacing between feed_we pulses SHALL be GAP_CYCLES+1 cycles.
REQ-020 feed_data and feed_src SHALL remain stable from the feed_we cycle until the next issue.
REQ-021 Latency: a character accepted at edge N into an empty system SHALL produce feed_we high in the cycle following edge N+1.
REQ-022 Selection priority: a head of 0xFF (clear) SHALL win, A before B if both; otherwise round-robin, granting the source not granted last.
REQ-023 Round-robin pointer SHALL update on every issue, including clears.
REQ-024 Issuing 0xFF SHALL set char_count to 0 and SHALL NOT pulse page_full.
REQ-025 Issuing any other code SHALL increment char_count; at 139 it wraps to 0 with page_full=1 in the same cycle as feed_we.
REQ-026 A FIFO SHALL NOT push and pop the same entry in one cycle; a simultaneous push to one entry and pop of another is allowed; pop on full SHALL re-assert x_ready the next cycle.
REQ-027 Character values SHALL pass unmodified; code translation is the feeder's job.

Reset
REQ-028 With rst high at an edge: FIFOs empty, FSM=IDLE, feed_we=0, feed_data=0, feed_src=0, char_count=0, page_full=0, round-robin pointer=B (so A wins first tie).
REQ-029 a_ready and b_ready SHALL be 0 while rst is high and 1 the cycle after release.
REQ-030 Reset mid-GAP or with full FIFOs SHALL discard all pending characters; no feed_we after the reset edge.

Verification
REQ-031 Single char: A sends 0x41 at edge 0 -> feed_we high in cycle after edge 1, feed_data=0x41, feed_src=0, char_count=1.
REQ-032 Contention: A and B each push 3 chars at once, GAP_CYCLES=1 -> issue order A,B,A,B,A,B, feed_we every 2 cycles.
REQ-033 Clear priority: A holds 0x30,0x31; B pushes 0xFF -> next issue is 0xFF from B, char_count=0.
REQ-034 Page wrap: 140 non-0xFF chars from A -> page_full pulses exactly once on the 140th feed_we, char_count returns to 0.
REQ-035 Backpressure: hold=1, A pushes 5 chars (FIFO_DEPTH=4) -> a_ready low after 4th; release hold -> 4 chars issue in order, 5th accepted after first pop.
REQ-036 Reset mid-stream: rst during GAP with both FIFOs non-empty -> all outputs at reset values, no further feed_we until new input.
